// File: rtl/smi_tx_packer_pkg.sv
// Shared SMI definitions (IOC codes, channel addresses, byte states), also reused by the RX controller.
package smi_tx_packer_pkg;

    typedef enum logic [1:0] {
        BYTE_0 = 2'd0,
        BYTE_1 = 2'd1,
        BYTE_2 = 2'd2,
        BYTE_3 = 2'd3
    } byte_state_t;

    localparam logic [2:0] SMI_ADDR_09     = 3'b100;
    localparam logic [2:0] SMI_ADDR_24     = 3'b101;
    localparam logic [2:0] SMI_ADDR_RESYNC = 3'b110;

    localparam logic [4:0] IOC_VERSION   = 5'b00000;
    localparam logic [4:0] IOC_TX_STATUS = 5'b00010;

    function automatic byte_state_t next_byte_state(input byte_state_t cur);
        return byte_state_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/smi_tx_packer_if.sv
// SMI write port, IOC register port and both TX FIFO push ports of the packer.
interface smi_tx_packer_if;
    logic [4:0]  i_ioc;
    logic        i_cs;
    logic        i_fetch_cmd;
    logic [7:0]  o_data_out;
    logic [2:0]  i_smi_a;
    logic        i_smi_swe_srw;
    logic [7:0]  i_smi_data_in;
    logic        o_smi_write_req;
    logic        o_fifo_09_push;
    logic [31:0] o_fifo_09_pushed_data;
    logic        i_fifo_09_full;
    logic        o_fifo_24_push;
    logic [31:0] o_fifo_24_pushed_data;
    logic        i_fifo_24_full;

    modport master (
        output i_ioc, i_cs, i_fetch_cmd, i_smi_a, i_smi_swe_srw, i_smi_data_in,
               i_fifo_09_full, i_fifo_24_full,
        input  o_data_out, o_smi_write_req, o_fifo_09_push, o_fifo_09_pushed_data,
               o_fifo_24_push, o_fifo_24_pushed_data
    );

    modport slave (
        input  i_ioc, i_cs, i_fetch_cmd, i_smi_a, i_smi_swe_srw, i_smi_data_in,
               i_fifo_09_full, i_fifo_24_full,
        output o_data_out, o_smi_write_req, o_fifo_09_push, o_fifo_09_pushed_data,
               o_fifo_24_push, o_fifo_24_pushed_data
    );
endinterface

// File: rtl/smi_word_packer.sv
// Packs four bytes MSB-first into a 32-bit word; push pulses one cycle after the 4th byte.
// FIFO full at the 4th byte drops the word and raises ovf_evt for that cycle; counter wraps regardless.
module smi_word_packer
    import smi_tx_packer_pkg::*;
(
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        wr_vld,
    input  logic [7:0]  wr_dat,
    input  logic        resync,
    input  logic        fifo_full,
    output logic        push_vld,
    output logic [31:0] push_dat,
    output logic        ovf_evt
);

    byte_state_t byte_state;
    logic [31:0] asm_word;
    logic [31:0] next_word;

    always_comb begin
        next_word = asm_word;
        case (byte_state)
            BYTE_0: next_word[31:24] = wr_dat;
            BYTE_1: next_word[23:16] = wr_dat;
            BYTE_2: next_word[15:8]  = wr_dat;
            BYTE_3: next_word[7:0]   = wr_dat;
            default: next_word = asm_word;
        endcase
    end

    assign ovf_evt = wr_vld && (byte_state == BYTE_3) && fifo_full;

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_state <= BYTE_0;
            asm_word   <= '0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
        end else begin
            push_vld <= 1'b0;
            if (resync) begin
                byte_state <= BYTE_0;
                asm_word   <= '0;
            end else if (wr_vld) begin
                asm_word   <= next_word;
                byte_state <= next_byte_state(byte_state);
                if (byte_state == BYTE_3 && !fifo_full) begin
                    push_vld <= 1'b1;
                    push_dat <= next_word;
                end
            end
        end
    end

endmodule

// File: rtl/smi_tx_packer.sv
// SMI write receiver: synchronizes the write strobe, decodes the channel address and packs bytes into 32-bit FIFO words.
// Latency: byte stored SYNC_STAGES-1 cycles after the strobe falls, push one cycle later; full FIFO drops the word (sticky overflow).
module smi_tx_packer
    import smi_tx_packer_pkg::*;
#(
    parameter logic [7:0] MODULE_VERSION = 8'h01,
    parameter int         SYNC_STAGES    = 3
) (
    input  logic             i_sys_clk,
    input  logic             i_reset,
    smi_tx_packer_if.slave   bus
);

    logic [SYNC_STAGES-1:0] swe_sync;
    logic [7:0]             data_pipe [SYNC_STAGES];
    logic [2:0]             addr_pipe [SYNC_STAGES];

    logic write_det;
    logic wr_09, wr_24, wr_resync, wr_wrong;
    logic ovf_09_evt, ovf_24_evt;
    logic ovf_09, ovf_24, wrong_addr;
    logic status_rd;

    // Data and address ride alongside the strobe so the oldest stages line up with the edge detect.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            swe_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= '0;
                addr_pipe[i] <= '0;
            end
        end else begin
            swe_sync     <= {swe_sync[SYNC_STAGES-2:0], bus.i_smi_swe_srw};
            data_pipe[0] <= bus.i_smi_data_in;
            addr_pipe[0] <= bus.i_smi_a;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= data_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign write_det = (swe_sync[SYNC_STAGES-1 -: 2] == 2'b10);
    assign wr_09     = write_det && (addr_pipe[SYNC_STAGES-1] == SMI_ADDR_09);
    assign wr_24     = write_det && (addr_pipe[SYNC_STAGES-1] == SMI_ADDR_24);
    assign wr_resync = write_det && (addr_pipe[SYNC_STAGES-1] == SMI_ADDR_RESYNC);
    assign wr_wrong  = write_det && !wr_09 && !wr_24 && !wr_resync;
    assign status_rd = bus.i_cs && bus.i_fetch_cmd && (bus.i_ioc == IOC_TX_STATUS);

    smi_word_packer u_pack_09 (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .wr_vld    (wr_09),
        .wr_dat    (data_pipe[SYNC_STAGES-1]),
        .resync    (wr_resync),
        .fifo_full (bus.i_fifo_09_full),
        .push_vld  (bus.o_fifo_09_push),
        .push_dat  (bus.o_fifo_09_pushed_data),
        .ovf_evt   (ovf_09_evt)
    );

    smi_word_packer u_pack_24 (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .wr_vld    (wr_24),
        .wr_dat    (data_pipe[SYNC_STAGES-1]),
        .resync    (wr_resync),
        .fifo_full (bus.i_fifo_24_full),
        .push_vld  (bus.o_fifo_24_push),
        .push_dat  (bus.o_fifo_24_pushed_data),
        .ovf_evt   (ovf_24_evt)
    );

    // A status read clears the sticky flags, but an event in the same cycle survives the clear.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            ovf_09          <= 1'b0;
            ovf_24          <= 1'b0;
            wrong_addr      <= 1'b0;
            bus.o_data_out  <= '0;
            bus.o_smi_write_req <= 1'b0;
        end else begin
            ovf_09     <= (ovf_09 && !status_rd) || ovf_09_evt;
            ovf_24     <= (ovf_24 && !status_rd) || ovf_24_evt;
            wrong_addr <= (wrong_addr && !status_rd) || wr_wrong;
            bus.o_smi_write_req <= !bus.i_fifo_09_full && !bus.i_fifo_24_full;
            if (bus.i_cs && bus.i_fetch_cmd) begin
                case (bus.i_ioc)
                    IOC_VERSION:   bus.o_data_out <= MODULE_VERSION;
                    IOC_TX_STATUS: bus.o_data_out <= {3'b000, wrong_addr, ovf_24, ovf_09,
                                                      bus.i_fifo_24_full, bus.i_fifo_09_full};
                    default:       bus.o_data_out <= bus.o_data_out;
                endcase
            end
        end
    end

endmodule

// File: doc/smi_tx_packer.md
SMI_TX_PACKER -- requirements
Module: smi_tx_packer

Interface
REQ-001 SHALL have parameter MODULE_VERSION, default 8'h01, value returned on the version IOC read.
REQ-002 SHALL have parameter SYNC_STAGES, default 3, length of the i_smi_swe_srw synchronizer (minimum 3).
REQ-003 SHALL have one clock and asynchronous active-high reset: i_sys_clk in 1 FPGA clock; i_reset in 1 asynchronous active-high reset.
REQ-004 i_ioc in 5 IOC register select; i_cs in 1 module select; i_fetch_cmd in 1 IOC read strobe; o_data_out out 8 IOC read data.
REQ-005 i_smi_a in 3 SMI address; i_smi_swe_srw in 1 SMI write strobe, asynchronous to i_sys_clk; i_smi_data_in in 8 SMI write data.
REQ-006 o_smi_write_req out 1 high when the block can accept SMI writes.
REQ-007 o_fifo_09_push out 1 push to the 0.9 GHz TX FIFO; o_fifo_09_pushed_data out 32 word to push; i_fifo_09_full in 1 FIFO full.
REQ-008 o_fifo_24_push out 1; o_fifo_24_pushed_data out 32; i_fifo_24_full in 1: same roles for the 2.4 GHz TX FIFO.

Function
REQ-009 SHALL shift i_smi_swe_srw through SYNC_STAGES registers and detect a write when the two oldest stages equal 2'b10 (synchronous falling edge).
REQ-010 SHALL delay i_smi_data_in and i_smi_a by the same number of stages, so the sampled byte and address are aligned with the detection cycle.
REQ-011 Address decode on a detected write: 3'b100 selects channel 09; 3'b101 selects channel 24; 3'b110 resynchronizes (data ignored); any other address is a wrong-address error.
REQ-012 Each channel SHALL have an independent 2-bit byte counter (states BYTE_0..BYTE_3) and a 32-bit assembly register.
REQ-013 Byte order SHALL be MSB first: BYTE_0 goes to bits [31:24], BYTE_1 to [23:16], BYTE_2 to [15:8], BYTE_3 to [7:0].
REQ-014 On the clock edge where a write is detected, the byte SHALL be stored and the counter advanced; BYTE_3 SHALL wrap to BYTE_0.
REQ-015 When a channel's BYTE_3 is stored and its FIFO full input is low at that edge, the push output SHALL be high for exactly the next cycle, with the complete word on the data output.
REQ-016 When that FIFO full input is high at that edge, the word SHALL be dropped (no push), the channel's sticky overflow flag set, and the counter still wraps to BYTE_0.
REQ-017 Push outputs SHALL otherwise be low; the data outputs SHALL hold their last value.
REQ-018 A resync write SHALL return both counters to BYTE_0 and discard any partial words.
REQ-019 A wrong-address write SHALL set the sticky wrong-address flag and leave both channels unchanged.
REQ-020 Interleaved writes to the two channels SHALL not disturb each other's partial words.
REQ-021 o_smi_write_req SHALL be registered and equal to !i_fifo_09_full && !i_fifo_24_full.
REQ-022 IOC read, when i_cs && i_fetch_cmd at an edge: ioc 5'b00000 returns MODULE_VERSION.
REQ-023 IOC read of ioc 5'b00010 (tx status) returns {3'b000, wrong_addr, ovf_24, ovf_09, full_24, full_09}.
REQ-024 A tx-status read SHALL clear all sticky flags; a flag set in the same cycle as the read SHALL win and remain set.
REQ-025 An IOC read of any other address SHALL leave o_data_out unchanged.

Reset
REQ-026 On i_reset asserted: counters BYTE_0, assembly registers 0, sticky flags 0, push outputs 0, pushed data 0, o_data_out 0, o_smi_write_req 0, synchronizers all 1 (idle high).
REQ-027 Reset asserted mid-word SHALL discard the partial word; no push SHALL occur until 4 new bytes are received.

Structure
REQ-028 IOC codes, SMI channel addresses (3'b100/3'b101/3'b110) and byte-state encodings SHALL live in a shared SMI package, reused by the RX controller.
REQ-029 Per-channel packing SHALL be one sub-module, smi_word_packer, instantiated twice; synchronizer, decode and IOC logic stay in the top level.

Verification
REQ-030 Write 0xDE,0xAD,0xBE,0xEF to a=3'b100 with FIFO not full -> single o_fifo_09_push pulse with data 32'hDEADBEEF; o_fifo_24_push stays low.
REQ-031 Interleave 0x11(a=100), 0xA1(a=101), 0x22, 0xA2, 0x33, 0xA3, 0x44, 0xA4 -> 09 pushes 32'h11223344 and 24 pushes 32'hA1A2A3A4.
REQ-032 Hold i_fifo_24_full=1 and write 4 bytes to a=101 -> no push; status read returns 8'h0A; a second status read returns 8'h02.
REQ-033 Write 2 bytes to a=100, write to a=110, then write 0x01,0x02,0x03,0x04 to a=100 -> push 32'h01020304.
REQ-034 Write to a=3'b010 -> no push, status bit4 set; assert reset after 3 bytes on a=100 -> all outputs return to reset values and no push occurs.
